vga_text_renderer: RTL

- Producer side of the pixel colour path: turns raster coordinates from the VGA timing generator into per-pixel foreground/background select plus 4-bit fg/bg colour indices.
- Those indices feed the colour-index-to-RGB decoder.
- Fetches character code and attribute from text VRAM, then the glyph row from font ROM, and overlays a blinking underline cursor.
- Pipelined 3 cycles; delays sync/enable to stay aligned.

---
 rtl/vga_text_renderer_if.sv | 40 ++++
 rtl/vga_text_renderer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer_if.sv
// Raster/memory bundle between the text renderer and its surroundings:
// timing generator, text VRAM, font ROM and the colour decoder.
interface vga_text_renderer_if #(
    parameter int unsigned CHAR_W = 8
);
    logic [9:0]        h_addr;
    logic [9:0]        v_addr;
    logic              de_in;
    logic              hsync_in;
    logic              vsync_in;
    logic              cursor_en;
    logic [6:0]        cursor_x;
    logic [4:0]        cursor_y;
    logic [11:0]       vram_addr;
    logic [15:0]       vram_data;
    logic [11:0]       font_addr;
    logic [CHAR_W-1:0] font_data;
    logic              fb;
    logic [3:0]        fg_color;
    logic [3:0]        bg_color;
    logic              de_out;
    logic              hsync_out;
    logic              vsync_out;

    modport master (
        output h_addr, v_addr, de_in, hsync_in, vsync_in,
        output cursor_en, cursor_x, cursor_y,
        output vram_data, font_data,
        input  vram_addr, font_addr,
        input  fb, fg_color, bg_color, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  h_addr, v_addr, de_in, hsync_in, vsync_in,
        input  cursor_en, cursor_x, cursor_y,
        input  vram_data, font_data,
        output vram_addr, font_addr,
        output fb, fg_color, bg_color, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/vga_text_renderer.sv
// Text-mode pixel producer: VRAM cell fetch, font row fetch and blinking
// underline cursor, 3-cycle pipeline with syncs delayed to match.
module vga_text_renderer #(
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_text_renderer_if.slave bus
);
    localparam int unsigned XW = $clog2(CHAR_W);
    localparam int unsigned YW = $clog2(CHAR_H);
    localparam int unsigned CW = 10 - XW;
    localparam int unsigned RW = 10 - YW;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Elaboration-time parameter sanity
    if ((32'(1) << XW) != CHAR_W) begin : g_bad_char_w
        $error("CHAR_W must be a power of 2");
    end
    if ((32'(1) << YW) != CHAR_H) begin : g_bad_char_h
        $error("CHAR_H must be a power of 2");
    end
    if (ROWS * COLS > 4096) begin : g_bad_cells
        $error("ROWS*COLS exceeds the 12-bit VRAM address space");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic          hit0;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    logic          s1_hit;
    logic          s1_de;
    logic          s1_hs;
    logic          s1_vs;

    logic [7:0]    s2_attr;
    logic [XW-1:0] s2_x;
    logic          s2_hit;
    logic          s2_de;
    logic          s2_hs;
    logic          s2_vs;

    logic          pixel;

    // Stage 0: cell coordinates, VRAM address and cursor hit
    always_comb begin
        col           = bus.h_addr[9:XW];
        row           = bus.v_addr[9:YW];
        x0            = bus.h_addr[XW-1:0];
        y0            = bus.v_addr[YW-1:0];
        bus.vram_addr = 12'(32'(row) * COLS + 32'(col));
        hit0          = bus.cursor_en & blink_phase
                      & (32'(col) == 32'(bus.cursor_x))
                      & (32'(row) == 32'(bus.cursor_y))
                      & (32'(y0) + 32'd2 >= CHAR_H);
    end

    // Stage 1: glyph row lookup from the freshly returned character code
    assign bus.font_addr = 12'({bus.vram_data[7:0], s1_y});

    // Stage 2: pick the pixel, MSB of the glyph row is leftmost
    assign pixel = bus.font_data[XW'(CHAR_W - 1) - s2_x];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x    <= '0;
            s1_y    <= '0;
            s1_hit  <= 1'b0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s2_attr <= '0;
            s2_x    <= '0;
            s2_hit  <= 1'b0;
            s2_de   <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
        end else begin
            s1_x    <= x0;
            s1_y    <= y0;
            s1_hit  <= hit0;
            s1_de   <= bus.de_in;
            s1_hs   <= bus.hsync_in;
            s1_vs   <= bus.vsync_in;
            s2_attr <= bus.vram_data[15:8];
            s2_x    <= s1_x;
            s2_hit  <= s1_hit;
            s2_de   <= s1_de;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

    // Frame counter on vsync rising edges; s1_vs doubles as the registered vsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.vsync_in && !s1_vs) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Output register: cursor inverts the glyph, blanking zeroes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fb        <= 1'b0;
            bus.fg_color  <= '0;
            bus.bg_color  <= '0;
            bus.de_out    <= 1'b0;
            bus.hsync_out <= 1'b0;
            bus.vsync_out <= 1'b0;
        end else begin
            bus.de_out    <= s2_de;
            bus.hsync_out <= s2_hs;
            bus.vsync_out <= s2_vs;
            if (s2_de) begin
                bus.fb       <= pixel ^ s2_hit;
                bus.fg_color <= s2_attr[3:0];
                bus.bg_color <= s2_attr[7:4];
            end else begin
                bus.fb       <= 1'b0;
                bus.fg_color <= '0;
                bus.bg_color <= '0;
            end
        end
    end
endmodule
